// File: rtl/hilo_mac_reg_pkg.sv
// Shared command codes and FSM state type for the HI/LO register pair
// with multiply-accumulate support.
package hilo_mac_reg_pkg;

  localparam logic [2:0] HILO_OP_NOP     = 3'b000;
  localparam logic [2:0] HILO_OP_WR_BOTH = 3'b001;
  localparam logic [2:0] HILO_OP_WR_HI   = 3'b010;
  localparam logic [2:0] HILO_OP_WR_LO   = 3'b011;
  localparam logic [2:0] HILO_OP_MADD    = 3'b100;
  localparam logic [2:0] HILO_OP_MSUB    = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } hilo_state_e;

endpackage

// File: rtl/hilo_mac_reg.sv
// HI/LO special-register pair: per-half and whole-pair writes, plus a
// two-cycle multiply-accumulate/subtract that stalls upstream via busy_o.
module hilo_mac_reg
  import hilo_mac_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic [2*DATA_W-1:0]   prod_i,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  busy_o
);

  hilo_state_e               state_q, state_d;
  logic [DATA_W-1:0]         hi_q, hi_d;
  logic [DATA_W-1:0]         lo_q, lo_d;
  logic [2*DATA_W-1:0]       prod_q, prod_d;
  logic                      sub_q, sub_d;
  logic                      acc_cmd;

  // Modulo 2^(2*DATA_W): the carry/borrow out is simply dropped.
  function automatic logic [2*DATA_W-1:0] acc_update(
    input logic [2*DATA_W-1:0] acc,
    input logic [2*DATA_W-1:0] prod,
    input logic                sub
  );
    return sub ? (acc - prod) : (acc + prod);
  endfunction

  assign acc_cmd = we && (op == HILO_OP_MADD || op == HILO_OP_MSUB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc_cmd) state_d = ST_ACC;
      ST_ACC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commands are only decoded in IDLE; anything presented during ACC is dropped.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    prod_d = prod_q;
    sub_d  = sub_q;
    if (state_q == ST_ACC) begin
      {hi_d, lo_d} = acc_update({hi_q, lo_q}, prod_q, sub_q);
    end else if (we) begin
      case (op)
        HILO_OP_NOP: ;
        HILO_OP_WR_BOTH: begin
          hi_d = hi_i;
          lo_d = lo_i;
        end
        HILO_OP_WR_HI: hi_d = hi_i;
        HILO_OP_WR_LO: lo_d = lo_i;
        HILO_OP_MADD, HILO_OP_MSUB: begin
          prod_d = prod_i;
          sub_d  = (op == HILO_OP_MSUB);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hi_o   = hi_q;
    lo_o   = lo_q;
    busy_o = (state_q == ST_ACC);
  end

endmodule

// File: tb/tb_hilo_mac_reg.sv
// Self-checking bench for hilo_mac_reg: directed scenarios plus randomized
// command streams checked against a 64-bit arithmetic reference model.
module tb_hilo_mac_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  op;
  logic [31:0] hi_i, lo_i;
  logic [63:0] prod_i;
  logic [31:0] hi_o, lo_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model;

  hilo_mac_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .we(we), .op(op),
    .hi_i(hi_i), .lo_i(lo_i), .prod_i(prod_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] o, input logic [31:0] h,
                       input logic [31:0] l, input logic [63:0] p);
    we = w; op = o; hi_i = h; lo_i = l; prod_i = p;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 64'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, 3'd1, 32'hCAFEF00D, 32'h0BADBEEF, 64'h0);
    step();
    idle();
    n_checks++;
    if ({hi_o, lo_o} !== 64'hCAFEF00D_0BADBEEF) begin
      n_fail++;
      $display("FAIL pre_reset_write: got %h want %h", {hi_o, lo_o}, 64'hCAFEF00D_0BADBEEF);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, hi_o, lo_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b val=%h want busy=0 val=0", busy_o, {hi_o, lo_o});
    end
    #1 rst = 1'b0;
    step();
    n_checks++;
    if ({busy_o, hi_o, lo_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got busy=%b val=%h want 0", busy_o, {hi_o, lo_o});
    end
    model = 64'h0;
  endtask

  task automatic test_half_writes();
    drive(1'b1, 3'd1, 32'h12345678, 32'h9ABCDEF0, 64'h0);
    step();
    n_checks++;
    if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin
      n_fail++;
      $display("FAIL wr_both: got %h want %h", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);
    end
    drive(1'b1, 3'd2, 32'hAAAAAAAA, 32'hFFFFFFFF, 64'h0);
    step();
    n_checks++;
    if ({hi_o, lo_o} !== 64'hAAAAAAAA_9ABCDEF0) begin
      n_fail++;
      $display("FAIL wr_hi: got %h want %h", {hi_o, lo_o}, 64'hAAAAAAAA_9ABCDEF0);
    end
    drive(1'b1, 3'd3, 32'hFFFFFFFF, 32'h55555555, 64'h0);
    step();
    n_checks++;
    if ({hi_o, lo_o} !== 64'hAAAAAAAA_55555555) begin
      n_fail++;
      $display("FAIL wr_lo: got %h want %h", {hi_o, lo_o}, 64'hAAAAAAAA_55555555);
    end
    drive(1'b0, 3'd1, 32'h11111111, 32'h22222222, 64'h0);
    step();
    n_checks++;
    if ({hi_o, lo_o} !== 64'hAAAAAAAA_55555555) begin
      n_fail++;
      $display("FAIL we_low_hold: got %h want %h", {hi_o, lo_o}, 64'hAAAAAAAA_55555555);
    end
    idle();
    model = 64'hAAAAAAAA_55555555;
  endtask

  task automatic test_madd_carry();
    drive(1'b1, 3'd1, 32'h0, 32'h5, 64'h0);
    step();
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'h00000000_FFFFFFFF);
    step();
    idle();
    n_checks++;
    if (busy_o !== 1'b1 || {hi_o, lo_o} !== 64'h5) begin
      n_fail++;
      $display("FAIL madd_busy: got busy=%b val=%h want busy=1 val=5", busy_o, {hi_o, lo_o});
    end
    step();
    n_checks++;
    if (busy_o !== 1'b0 || {hi_o, lo_o} !== 64'h00000001_00000004) begin
      n_fail++;
      $display("FAIL madd_result: got busy=%b val=%h want busy=0 val=%h", busy_o, {hi_o, lo_o}, 64'h00000001_00000004);
    end
    model = 64'h00000001_00000004;
  endtask

  task automatic test_wrap();
    drive(1'b1, 3'd1, 32'h0, 32'h0, 64'h0);
    step();
    drive(1'b1, 3'd5, 32'h0, 32'h0, 64'h1);
    step();
    idle();
    step();
    n_checks++;
    if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFF) begin
      n_fail++;
      $display("FAIL msub_wrap: got %h want %h", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
    end
    // second MADD issued on the first IDLE cycle after ACC
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'h1);
    step();
    idle();
    step();
    n_checks++;
    if ({busy_o, hi_o, lo_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL madd_carry_discard: got busy=%b val=%h want 0", busy_o, {hi_o, lo_o});
    end
    model = 64'h0;
  endtask

  task automatic test_busy_ignore();
    drive(1'b1, 3'd1, 32'h0, 32'h10, 64'h0);
    step();
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'h00000002_00000003);
    step();
    drive(1'b1, 3'd1, 32'hDEADBEEF, 32'hDEADBEEF, 64'h0);
    step();
    idle();
    n_checks++;
    if ({busy_o, hi_o, lo_o} !== {1'b0, 64'h00000002_00000013}) begin
      n_fail++;
      $display("FAIL busy_ignore: got busy=%b val=%h want %h", busy_o, {hi_o, lo_o}, 64'h00000002_00000013);
    end
    step();
    n_checks++;
    if ({hi_o, lo_o} !== 64'h00000002_00000013) begin
      n_fail++;
      $display("FAIL busy_ignore_hold: got %h want %h", {hi_o, lo_o}, 64'h00000002_00000013);
    end
    model = 64'h00000002_00000013;
  endtask

  task automatic test_reset_during_acc();
    drive(1'b1, 3'd1, 32'h01234567, 32'h89ABCDEF, 64'h0);
    step();
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'h00000000_00000100);
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, hi_o, lo_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_in_acc: got busy=%b val=%h want 0", busy_o, {hi_o, lo_o});
    end
    #1 rst = 1'b0;
    step();
    step();
    n_checks++;
    if ({busy_o, hi_o, lo_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_no_partial: got busy=%b val=%h want 0", busy_o, {hi_o, lo_o});
    end
    model = 64'h0;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic        w;
    logic [31:0] h, l;
    logic [63:0] p, expect_v;
    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 7) != 0);
      o = 3'($urandom_range(0, 7));
      h = $urandom;
      l = $urandom;
      p = {$urandom, $urandom};
      drive(w, o, h, l, p);
      expect_v = model;
      if (w) begin
        case (o)
          3'd1: expect_v = {h, l};
          3'd2: expect_v = {h, model[31:0]};
          3'd3: expect_v = {model[63:32], l};
          default: expect_v = model;
        endcase
      end
      step();
      if (w && (o == 3'd4 || o == 3'd5)) begin
        n_checks++;
        if (busy_o !== 1'b1 || {hi_o, lo_o} !== model) begin
          n_fail++;
          $display("FAIL rand_accept[%0d]: got busy=%b val=%h want busy=1 val=%h", i, busy_o, {hi_o, lo_o}, model);
        end
        drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, {$urandom, $urandom});
        expect_v = (o == 3'd4) ? model + p : model - p;
        step();
      end
      n_checks++;
      if (busy_o !== 1'b0 || {hi_o, lo_o} !== expect_v) begin
        n_fail++;
        $display("FAIL rand_result[%0d] op=%0d we=%b: got busy=%b val=%h want busy=0 val=%h", i, o, w, busy_o, {hi_o, lo_o}, expect_v);
      end
      model = expect_v;
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model = 64'h0;
    #12 rst = 1'b0;
    step();
    n_checks++;
    if ({busy_o, hi_o, lo_o} !== 65'h0) begin
      n_fail++;
      $display("FAIL initial_reset: got busy=%b val=%h want 0", busy_o, {hi_o, lo_o});
    end
    test_reset();
    test_half_writes();
    test_madd_carry();
    test_wrap();
    test_busy_ignore();
    test_reset_during_acc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
